// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmit serializer fed from an FWFT FIFO, with underrun mute
module i2s_tx_serializer #(
  parameter int PKT_WIDTH  = 16,
  parameter int MUTE_AFTER = 4
) (
  input  logic                 clkI2SBit_i,
  input  logic                 rstI2S_n_i,
  input  logic [PKT_WIDTH-1:0] fifoPkt_i,
  input  logic                 fifoEmpty_i,
  output logic                 fifoRdEn_o,
  output logic                 i2sLRCLK_o,
  output logic                 i2sSD_o,
  output logic                 underflow_o,
  output logic [7:0]           underflowCnt_o
);

  localparam int CW = $clog2(2 * PKT_WIDTH);
  localparam int IW = (PKT_WIDTH > 1) ? $clog2(PKT_WIDTH) : 1;
  localparam int UW = $clog2(MUTE_AFTER + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(2 * PKT_WIDTH - 1);
  localparam logic [CW-1:0] SLOT_W   = CW'(PKT_WIDTH);
  localparam logic [CW-1:0] LR_LO    = CW'(PKT_WIDTH - 1);
  localparam logic [CW-1:0] LR_HI    = CW'(2 * PKT_WIDTH - 2);
  localparam logic [UW-1:0] MUTE_CNT = UW'(MUTE_AFTER);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PKT_WIDTH-1:0]   sample_q, sample_d;
  logic [UW-1:0]          cons_q, cons_d;
  logic [7:0]             uf_cnt_q, uf_cnt_d;
  logic                   rd_en_q, rd_en_d;
  logic                   uf_q, uf_d;
  logic                   sd_q, sd_d;
  logic                   lrclk_q, lrclk_d;

  logic                   load;
  logic [CW-1:0]          slot_pos;
  logic [CW-1:0]          bit_idx;

  // Next-state: frame counter, load decisions, and the output bits for the coming cycle
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    cons_d   = cons_q;
    uf_cnt_d = uf_cnt_q;
    rd_en_d  = 1'b0;
    uf_d     = 1'b0;

    load  = (cnt_q == CNT_LAST);
    cnt_d = load ? '0 : cnt_q + 1'b1;

    if (load) begin
      if (!fifoEmpty_i) begin
        sample_d = fifoPkt_i;
        rd_en_d  = 1'b1;
        state_d  = S_RUN;
        cons_d   = '0;
      end else if (state_q == S_IDLE) begin
        sample_d = '0;
      end else begin
        cons_d = cons_q + 1'b1;
        uf_d   = 1'b1;
        if (uf_cnt_q != 8'hFF) begin
          uf_cnt_d = uf_cnt_q + 8'd1;
        end
        // Sustained underrun: stop repeating the stale sample and go quiet
        if (cons_d == MUTE_CNT) begin
          sample_d = '0;
          state_d  = S_IDLE;
        end
      end
    end

    // Both slots carry the same sample, MSB first
    slot_pos = (cnt_d >= SLOT_W) ? cnt_d - SLOT_W : cnt_d;
    bit_idx  = LR_LO - slot_pos;
    sd_d     = sample_d[bit_idx[IW-1:0]];
    // Word select leads each slot MSB by one bit clock
    lrclk_d  = (cnt_d >= LR_LO) && (cnt_d <= LR_HI);
  end

  // State and output registers
  always_ff @(posedge clkI2SBit_i or negedge rstI2S_n_i) begin
    if (!rstI2S_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_LAST;
      sample_q <= '0;
      cons_q   <= '0;
      uf_cnt_q <= '0;
      rd_en_q  <= 1'b0;
      uf_q     <= 1'b0;
      sd_q     <= 1'b0;
      lrclk_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      cons_q   <= cons_d;
      uf_cnt_q <= uf_cnt_d;
      rd_en_q  <= rd_en_d;
      uf_q     <= uf_d;
      sd_q     <= sd_d;
      lrclk_q  <= lrclk_d;
    end
  end

  assign fifoRdEn_o     = rd_en_q;
  assign i2sLRCLK_o     = lrclk_q;
  assign i2sSD_o        = sd_q;
  assign underflow_o    = uf_q;
  assign underflowCnt_o = uf_cnt_q;

endmodule
